scoreboard_register_file: RTL
=============================

# scoreboard_register_file

Parametrised general-purpose register file for the processor datapath: three combinational read ports (A, B, D) and one synchronous write port (C). It adds an honoured write enable, optional write-to-read bypass, optional hardwired-zero R0, a per-register pending-write scoreboard for long-latency ops, and a sequential clear-sweep engine. It sits between decode (reads, issue marking) and writeback (port C).

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; NUM_REGS = 2**ADDR_W (derived localparam)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports
- ZERO_R0, 0, 1 = R0 reads 0, ignores writes and issue marks

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- w_en  in  1  write enable for port C
- addr_c  in  ADDR_W  write address
- data_c  in  DATA_W  write data
- addr_a / addr_b / addr_d  in  ADDR_W  read addresses
- data_a / data_b / data_d  out  DATA_W  read data
- rdy_a / rdy_b / rdy_d  out  1  addressed register has no pending write
- iss_en  in  1  mark addr_iss pending (long-latency op issued)
- addr_iss  in  ADDR_W  register to mark pending
- clr_req  in  1  start clear sweep
- clr_busy  out  1  sweep in progress
- clr_done  out  1  one-cycle pulse, sweep finished

## Operation
- Write: on rising edge with w_en=1 and FSM not SWEEP, reg[addr_c] <= data_c and pending[addr_c] <= 0. w_en=0 writes nothing.
- Read: data_x = reg[addr_x] combinationally. BYPASS=1: if w_en=1, addr_c==addr_x, FSM IDLE/DONE, rst high, data_x = data_c.
- ZERO_R0=1: address 0 reads 0 (priority over bypass); writes and iss_en to R0 dropped; rdy for R0 always 1.
- Scoreboard: iss_en=1 sets pending[addr_iss] at next edge. iss_en and w_en to same address same cycle: set wins (pending=1, data still written).
- rdy_x = ~pending[addr_x]; BYPASS=1 also forces rdy_x=1 when bypass hit applies.
- Clear FSM states IDLE, SWEEP, DONE.
  - IDLE: clr_req=1 -> SWEEP, idx <= 0.
  - SWEEP: each edge reg[idx] <= 0, pending[idx] <= 0, idx++; at idx==NUM_REGS-1 -> DONE.
  - DONE: one cycle, clr_done=1 -> IDLE. Normal writes/issues accepted in DONE.
  - clr_req outside IDLE ignored. During SWEEP: w_en, iss_en ignored, bypass off, rdy_a/b/d = 0.
- Reset (rst low, async): all regs 0, pending 0, FSM IDLE, idx 0; data_x = 0 (bypass gated), rdy_x = 1, clr_busy 0, clr_done 0. Reset mid-sweep aborts it; no clr_done.

## Timing
- Write-to-read latency: 1 edge (0 with BYPASS=1).
- iss_en edge k -> rdy low from cycle k+1 until writeback edge.
- clr_req sampled edge k -> clr_busy high cycles k+1..k+NUM_REGS; clr_done high cycle k+NUM_REGS+1; full sweep NUM_REGS cycles.
- idx width ADDR_W, no wrap beyond NUM_REGS-1.

## Structure
- Package regfile_pkg: clear-state enum (IDLE, SWEEP, DONE), default DATA_W/ADDR_W constants.
- One sub-module: rf_scoreboard (pending bit vector, set/clear priority, sweep-clear input, rdy lookup for three ports). Storage, read muxes, bypass, clear FSM in top.

## Test plan
- Reset, write 16'hBEEF to R5 (w_en=1), read A=5 next cycle -> data_a=16'hBEEF, rdy_a=1; w_en=0 write of 16'h1234 -> R5 stays 16'hBEEF.
- BYPASS=1: write 16'h00A5 to R3, same cycle addr_b=3 -> data_b=16'h00A5; BYPASS=0 -> data_b=old value 0.
- iss_en R7 -> rdy_d=0 for addr_d=7; writeback 16'h0042 to R7 -> rdy_d=1 next cycle, data 16'h0042; simultaneous iss_en+w_en R7 -> rdy_d stays 0.
- ZERO_R0=1: write 16'hFFFF to R0, iss_en R0 -> data_a=0, rdy_a=1.
- Fill all regs, pulse clr_req -> clr_busy 16 cycles, writes ignored, clr_done one cycle, all reads 0, all rdy 1.
- Assert rst at sweep cycle 6 -> regs 0, clr_busy 0, no clr_done, FSM IDLE after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default widths for the scoreboarded register file.
package regfile_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;

    // Clear-sweep engine states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue of a
// long-latency op, cleared by writeback or by the clear sweep.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              sweep_en,
    input  logic [ADDR_W-1:0] sweep_addr,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] addr_d,
    output logic              rdy_a,
    output logic              rdy_b,
    output logic              rdy_d
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Next pending vector: sweep overrides everything; otherwise an issue
    // mark to the same register as a writeback wins over the clear.
    always_comb begin
        pending_d = pending_q;
        if (sweep_en) begin
            pending_d[sweep_addr] = 1'b0;
        end else begin
            if (clr_en) pending_d[clr_addr] = 1'b0;
            if (set_en) pending_d[set_addr] = 1'b1;
        end
    end

    // Pending bit register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pending_q <= '0;
        else      pending_q <= pending_d;
    end

    assign rdy_a = ~pending_q[addr_a];
    assign rdy_b = ~pending_q[addr_b];
    assign rdy_d = ~pending_q[addr_d];

endmodule

// File: rtl/scoreboard_register_file.sv
// Register file with three combinational read ports, one write port,
// optional write bypass and hardwired R0, a pending-write scoreboard and a
// sequential clear-sweep engine.
module scoreboard_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] addr_c,
    input  logic [DATA_W-1:0] data_c,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] addr_d,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] data_d,
    output logic              rdy_a,
    output logic              rdy_b,
    output logic              rdy_d,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] addr_iss,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int                NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    // True when the address is the hardwired zero register
    function automatic logic r0_hard(input logic [ADDR_W-1:0] a);
        return (ZERO_R0 != 0) && (a == '0);
    endfunction

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] regs [NUM_REGS];

    logic sweeping;
    logic wr_ok;
    logic iss_ok;
    logic byp_on;
    logic hit_a, hit_b, hit_d;
    logic sb_rdy_a, sb_rdy_b, sb_rdy_d;

    assign sweeping = (state_q == SWEEP);
    assign wr_ok    = w_en   && !sweeping && !r0_hard(addr_c);
    assign iss_ok   = iss_en && !sweeping && !r0_hard(addr_iss);
    // Forwarding is suppressed during the sweep and while reset is held
    assign byp_on   = (BYPASS != 0) && w_en && rst && !sweeping;

    assign hit_a = byp_on && (addr_c == addr_a);
    assign hit_b = byp_on && (addr_c == addr_b);
    assign hit_d = byp_on && (addr_c == addr_d);

    // Clear FSM state and sweep index registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Clear FSM next-state and status outputs
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        clr_busy = 1'b0;
        clr_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                clr_busy = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            DONE: begin
                clr_done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Register storage: sweep clears one entry per cycle, otherwise port C writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (sweeping) begin
            regs[idx_q] <= '0;
        end else if (wr_ok) begin
            regs[addr_c] <= data_c;
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en     (iss_ok),
        .set_addr   (addr_iss),
        .clr_en     (wr_ok),
        .clr_addr   (addr_c),
        .sweep_en   (sweeping),
        .sweep_addr (idx_q),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .addr_d     (addr_d),
        .rdy_a      (sb_rdy_a),
        .rdy_b      (sb_rdy_b),
        .rdy_d      (sb_rdy_d)
    );

    // Read muxes: hardwired R0 beats bypass, bypass beats storage
    assign data_a = r0_hard(addr_a) ? '0 : (hit_a ? data_c : regs[addr_a]);
    assign data_b = r0_hard(addr_b) ? '0 : (hit_b ? data_c : regs[addr_b]);
    assign data_d = r0_hard(addr_d) ? '0 : (hit_d ? data_c : regs[addr_d]);

    assign rdy_a = sweeping ? 1'b0 : ((r0_hard(addr_a) || hit_a) ? 1'b1 : sb_rdy_a);
    assign rdy_b = sweeping ? 1'b0 : ((r0_hard(addr_b) || hit_b) ? 1'b1 : sb_rdy_b);
    assign rdy_d = sweeping ? 1'b0 : ((r0_hard(addr_d) || hit_d) ? 1'b1 : sb_rdy_d);

endmodule
